// File: rtl/rot_pkg.sv
// Shared constants and helpers for the rotate-sharing arbiter and its rotator core.
package rot_pkg;

  localparam int ROT_W     = 32;
  localparam int ROT_AMT_W = 5;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  // A left rotate by k is the same as a right rotate by (32 - k) mod 32.
  function automatic logic [ROT_AMT_W-1:0] left_to_right_amt(input logic [ROT_AMT_W-1:0] amt);
    return (~amt) + ROT_AMT_W'(1);
  endfunction

endpackage

// File: rtl/rot32_core.sv
// Purely combinational 32-bit right rotator built as a 5-stage logarithmic shifter.
module rot32_core
  import rot_pkg::*;
(
  input  logic [ROT_W-1:0]     din,
  input  logic [ROT_AMT_W-1:0] amt,
  output logic [ROT_W-1:0]     dout
);

  logic [ROT_AMT_W:0][ROT_W-1:0] stage;

  assign stage[0] = din;

  // Stage s rotates right by 2**s when amount bit s is set.
  for (genvar s = 0; s < ROT_AMT_W; s++) begin : g_stage
    localparam int SH = 1 << s;
    assign stage[s+1] = amt[s] ? {stage[s][SH-1:0], stage[s][ROT_W-1:SH]} : stage[s];
  end

  assign dout = stage[ROT_AMT_W];

endmodule

// File: rtl/rot_share_arb.sv
// Round-robin arbiter sharing one barrel rotator among NREQ requesters,
// with a one-deep registered output stage and a completed-operation counter.
module rot_share_arb
  import rot_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 3,
  parameter int CNTW = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*ROT_W-1:0]     req_data,
  input  logic [NREQ*ROT_AMT_W-1:0] req_amt,
  input  logic [NREQ-1:0]           req_dir,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ROT_W-1:0]          out_data,
  output logic [IDW-1:0]            out_id,
  output logic [CNTW-1:0]           op_count
);

  logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
  logic                 out_valid_q, out_valid_d;
  logic [ROT_W-1:0]     out_data_q, out_data_d;
  logic [IDW-1:0]       out_id_q, out_id_d;
  logic [CNTW-1:0]      op_count_q, op_count_d;

  logic [IDW-1:0]       gnt;
  logic                 found;
  logic                 accept;
  logic                 xfer;
  logic [ROT_W-1:0]     sel_data;
  logic [ROT_AMT_W-1:0] sel_amt;
  logic                 sel_dir;
  logic [ROT_AMT_W-1:0] core_amt;
  logic [ROT_W-1:0]     rot_data;

  // Two passes give the wrapped search: first indices at or above the pointer, then from zero.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_valid[i] && (IDW'(i) >= rr_ptr_q)) begin
        gnt   = IDW'(i);
        found = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req_valid[i]) begin
        gnt   = IDW'(i);
        found = 1'b1;
      end
    end
  end

  assign accept = !out_valid_q || out_ready;
  assign xfer   = accept && found && rst_n;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = xfer && (gnt == IDW'(i));
    end
  end

  always_comb begin
    sel_data = '0;
    sel_amt  = '0;
    sel_dir  = DIR_RIGHT;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt == IDW'(i)) begin
        sel_data = req_data[i*ROT_W +: ROT_W];
        sel_amt  = req_amt[i*ROT_AMT_W +: ROT_AMT_W];
        sel_dir  = req_dir[i];
      end
    end
  end

  assign core_amt = (sel_dir == DIR_LEFT) ? left_to_right_amt(sel_amt) : sel_amt;

  rot32_core u_rot (
    .din  (sel_data),
    .amt  (core_amt),
    .dout (rot_data)
  );

  // The output register reloads on a transfer, empties on a drain, and otherwise holds.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    op_count_d  = op_count_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      op_count_d  = op_count_q + CNTW'(1);
    end
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = rot_data;
      out_id_d    = gnt;
      rr_ptr_d    = (gnt == IDW'(NREQ-1)) ? '0 : gnt + IDW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      op_count_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      op_count_q  <= op_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_rot_share_arb.sv
// Randomized and directed bench for rot_share_arb, checked against a transaction-level model.
module tb_rot_share_arb;

  localparam int NREQ = 4;
  localparam int IDW  = 3;
  localparam int CNTW = 16;

  logic                clk = 1'b0;
  logic                rstN;
  logic [NREQ-1:0]     reqValid;
  logic [NREQ-1:0]     reqReady;
  logic [NREQ*32-1:0]  reqData;
  logic [NREQ*5-1:0]   reqAmt;
  logic [NREQ-1:0]     reqDir;
  logic                outValid;
  logic                outReady;
  logic [31:0]         outData;
  logic [IDW-1:0]      outId;
  logic [CNTW-1:0]     opCount;

  always #5 clk = ~clk;

  rot_share_arb #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst_n     (rstN),
    .req_valid (reqValid),
    .req_ready (reqReady),
    .req_data  (reqData),
    .req_amt   (reqAmt),
    .req_dir   (reqDir),
    .out_valid (outValid),
    .out_ready (outReady),
    .out_data  (outData),
    .out_id    (outId),
    .op_count  (opCount)
  );

  int checkCount = 0;
  int errorCount = 0;

  logic        expValid;
  logic [31:0] expData;
  int          expId;
  int          expCount;
  int          rrPtr;
  logic [NREQ-1:0] lastReady;

  logic [NREQ-1:0] laneValid;
  logic [31:0]     laneData [NREQ];
  logic [4:0]      laneAmt  [NREQ];
  logic            laneDir  [NREQ];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Rotation defined bit by bit: right takes bit (j+k), left takes bit (j-k).
  function automatic logic [31:0] refRotate(input logic [31:0] w, input int k, input logic left);
    logic [31:0] r;
    for (int j = 0; j < 32; j++) begin
      r[j] = left ? w[(j - k + 32) % 32] : w[(j + k) % 32];
    end
    return r;
  endfunction

  function automatic int refGrant(input logic [NREQ-1:0] v, input int ptr);
    for (int off = 0; off < NREQ; off++) begin
      if (v[(ptr + off) % NREQ]) return (ptr + off) % NREQ;
    end
    return -1;
  endfunction

  task automatic modelReset();
    expValid  = 1'b0;
    expData   = '0;
    expId     = 0;
    expCount  = 0;
    rrPtr     = 0;
    lastReady = '0;
  endtask

  // One cycle: drive at the falling edge, check just after, then advance the model past the next rising edge.
  task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [NREQ*32-1:0] d,
                               input logic [NREQ*5-1:0] a, input logic [NREQ-1:0] dr, input logic oRdy);
    int g;
    logic acc;
    logic [NREQ-1:0] er;
    @(negedge clk);
    reqValid = v;
    reqData  = d;
    reqAmt   = a;
    reqDir   = dr;
    outReady = oRdy;
    #1;
    checkOutput("out_valid", 32'(outValid), 32'(expValid));
    checkOutput("out_data", outData, expData);
    checkOutput("out_id", 32'(outId), 32'(expId));
    checkOutput("op_count", 32'(opCount), 32'(expCount));
    acc = !expValid || oRdy;
    g   = refGrant(v, rrPtr);
    er  = '0;
    if (acc && g >= 0) er[g] = 1'b1;
    checkOutput("req_ready", 32'(reqReady), 32'(er));
    lastReady = er;
    if (expValid && oRdy) expCount = (expCount + 1) % (1 << CNTW);
    if (er != '0) begin
      expData  = refRotate(d[g*32 +: 32], int'(a[g*5 +: 5]), dr[g]);
      expId    = g;
      expValid = 1'b1;
      rrPtr    = (g + 1) % NREQ;
    end else if (oRdy) begin
      expValid = 1'b0;
    end
  endtask

  task automatic stepLanes(input logic oRdy);
    logic [NREQ*32-1:0] d;
    logic [NREQ*5-1:0]  a;
    logic [NREQ-1:0]    dr;
    for (int i = 0; i < NREQ; i++) begin
      d[i*32 +: 32] = laneData[i];
      a[i*5 +: 5]   = laneAmt[i];
      dr[i]         = laneDir[i];
    end
    applyStimulus(laneValid, d, a, dr, oRdy);
  endtask

  task automatic clearLanes();
    laneValid = '0;
    for (int i = 0; i < NREQ; i++) begin
      laneData[i] = '0;
      laneAmt[i]  = '0;
      laneDir[i]  = 1'b0;
    end
  endtask

  // Reset is asserted mid-cycle so the asynchronous clear is visible before any clock edge.
  task automatic doReset();
    @(posedge clk);
    #2;
    reqValid = '1;
    rstN = 1'b0;
    #1;
    checkOutput("rst_out_valid", 32'(outValid), 32'd0);
    checkOutput("rst_op_count", 32'(opCount), 32'd0);
    checkOutput("rst_req_ready", 32'(reqReady), 32'd0);
    modelReset();
    reqValid = '0;
    outReady = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
  endtask

  logic [31:0] t2Data [4] = '{32'h12345678, 32'h00000001, 32'hDEADBEEF, 32'hDEADBEEF};
  logic [4:0]  t2Amt  [4] = '{5'd4, 5'd31, 5'd0, 5'd0};
  logic        t2Dir  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic [31:0] t2Exp  [4] = '{32'h23456781, 32'h00000002, 32'hDEADBEEF, 32'hDEADBEEF};

  initial begin
    rstN     = 1'b0;
    reqValid = '1;
    reqData  = '0;
    reqAmt   = '0;
    reqDir   = '0;
    outReady = 1'b0;
    modelReset();
    clearLanes();
    repeat (2) @(negedge clk);
    #1;
    checkOutput("init_out_valid", 32'(outValid), 32'd0);
    checkOutput("init_out_data", outData, 32'd0);
    checkOutput("init_out_id", 32'(outId), 32'd0);
    checkOutput("init_op_count", 32'(opCount), 32'd0);
    checkOutput("init_req_ready", 32'(reqReady), 32'd0);
    reqValid = '0;
    rstN = 1'b1;

    // Single request on lane 0.
    laneValid[0] = 1'b1;
    laneData[0]  = 32'h80000001;
    laneAmt[0]   = 5'd1;
    stepLanes(1'b1);
    clearLanes();
    stepLanes(1'b1);
    checkOutput("t1_valid", 32'(outValid), 32'd1);
    checkOutput("t1_data", outData, 32'hC0000000);
    checkOutput("t1_id", 32'(outId), 32'd0);
    stepLanes(1'b1);
    checkOutput("t1_count", 32'(opCount), 32'd1);

    // Direction and boundary amounts on lane 2.
    for (int c = 0; c < 4; c++) begin
      laneValid[2] = 1'b1;
      laneData[2]  = t2Data[c];
      laneAmt[2]   = t2Amt[c];
      laneDir[2]   = t2Dir[c];
      stepLanes(1'b1);
      clearLanes();
      stepLanes(1'b1);
      checkOutput("t2_data", outData, t2Exp[c]);
      checkOutput("t2_id", 32'(outId), 32'd2);
    end

    // All lanes valid: back-to-back round robin.
    doReset();
    laneValid = '1;
    for (int i = 0; i < NREQ; i++) begin
      laneData[i] = $urandom;
      laneAmt[i]  = 5'($urandom_range(0, 31));
      laneDir[i]  = 1'($urandom_range(0, 1));
    end
    for (int k = 0; k < 7; k++) begin
      stepLanes(1'b1);
      if (k >= 1) begin
        checkOutput("t3_valid", 32'(outValid), 32'd1);
        checkOutput("t3_id", 32'(outId), 32'((k - 1) % NREQ));
      end
    end

    // Backpressure with lanes 1 and 3.
    doReset();
    clearLanes();
    laneValid = 4'b1010;
    laneData[1] = 32'h0000F00D;
    laneData[3] = 32'hCAFE0000;
    laneAmt[3]  = 5'd16;
    stepLanes(1'b1);
    laneValid[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      stepLanes(1'b0);
      checkOutput("t4_hold_id", 32'(outId), 32'd1);
      checkOutput("t4_hold_data", outData, 32'h0000F00D);
      checkOutput("t4_ready", 32'(reqReady), 32'd0);
    end
    stepLanes(1'b1);
    checkOutput("t4_rel_ready", 32'(reqReady), 32'b1000);
    clearLanes();
    stepLanes(1'b1);
    checkOutput("t4_second_id", 32'(outId), 32'd3);
    checkOutput("t4_second_data", outData, 32'h0000CAFE);

    // Pointer fairness across the wrap.
    doReset();
    clearLanes();
    laneValid = 4'b1000;
    stepLanes(1'b1);
    checkOutput("t5_first", 32'(reqReady), 32'b1000);
    laneValid = 4'b1001;
    stepLanes(1'b1);
    checkOutput("t5_wrap", 32'(reqReady), 32'b0001);
    stepLanes(1'b1);
    checkOutput("t5_back", 32'(reqReady), 32'b1000);
    clearLanes();
    stepLanes(1'b1);

    // Reset while stalled with a pending result.
    laneValid = 4'b0010;
    laneData[1] = 32'h01234567;
    stepLanes(1'b1);
    clearLanes();
    stepLanes(1'b0);
    checkOutput("t6_stalled", 32'(outValid), 32'd1);
    doReset();
    laneValid = 4'b0110;
    stepLanes(1'b1);
    checkOutput("t6_lowest", 32'(reqReady), 32'b0010);
    clearLanes();
    stepLanes(1'b1);

    // Random traffic; a waiting requester keeps its request stable until accepted.
    doReset();
    clearLanes();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!(laneValid[i] && !lastReady[i])) begin
          laneValid[i] = ($urandom_range(0, 9) < 6);
          laneData[i]  = $urandom;
          laneAmt[i]   = 5'($urandom_range(0, 31));
          laneDir[i]   = 1'($urandom_range(0, 1));
        end
      end
      stepLanes($urandom_range(0, 3) != 0);
    end
    clearLanes();
    repeat (3) stepLanes(1'b1);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/rot_share_arb.md
Name: rot_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one 32-bit barrel rotator among NREQ requesters.
- Each requester presents a word, a rotation amount and a direction over a valid/ready handshake.
- The block grants one request per cycle and drives the shared rotator.
- Results go out through a one-deep registered output stage with backpressure, tagged with the requester index.
- Sits between the per-lane datapath clients and the shared rotate unit.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- IDW, 3, width of the requester index tag; must satisfy 2**IDW >= NREQ.
- CNTW, 16, width of the completed-operation counter.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset; asserts immediately, deasserts synchronously to clk.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle.
- req_data  in  NREQ*32  packed request words; requester i uses bits [32i+31:32i].
- req_amt  in  NREQ*5  packed rotation amounts, 0..31.
- req_dir  in  NREQ  rotation direction; 0 = right, 1 = left.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_data  out  32  rotated word.
- out_id  out  IDW  index of the requester that produced out_data.
- op_count  out  CNTW  count of completed output handshakes; wraps modulo 2**CNTW.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_id=0, op_count=0, round-robin pointer rr_ptr=0. req_ready is 0 while rst_n=0.
- Accept condition: accept = !out_valid || out_ready, so the output stage is bubble-free when downstream is continuously ready.
- Grant rule: gnt is the first index i with req_valid[i]=1, searching from rr_ptr upward and wrapping at NREQ-1 -> 0.
- Ready rule: req_ready[gnt] = accept && |req_valid, and is combinational. No other req_ready bit is ever high.
- Handshake completion: a request transfers when req_valid[i] && req_ready[i] in the same cycle.
- On a transfer, next edge:
  - out_data <= rotate(req_data[gnt], req_amt[gnt], req_dir[gnt]).
  - out_id <= gnt.
  - out_valid <= 1.
  - rr_ptr <= (gnt+1) mod NREQ.
- rr_ptr moves only on a transfer; with no request, or while stalled, it holds.
- Rotate arithmetic:
  - Right rotate by k: bit j of the result = input bit (j+k) mod 32.
  - Left rotate by k is implemented as a right rotate by (32-k) mod 32, computed in 5-bit unsigned arithmetic.
  - k=0 passes the input through for either direction.
  - k=31 right equals a 1-bit left rotate.
- Latency: exactly 1 cycle from request handshake to out_valid.
- Throughput: 1 result per cycle.
- Stall: if out_valid && !out_ready, then out_valid, out_data and out_id hold stable, all req_ready=0, and rr_ptr holds.
- Simultaneous drain and fill: when out_ready=1 and a request is granted in the same cycle, the register reloads with the new result and out_valid stays 1.
- Drain with no new request: when out_ready=1 and no request is granted, out_valid <= 0 and out_data/out_id hold their last values.
- op_count increments by 1 on every out_valid && out_ready and wraps from 2**CNTW-1 to 0.
- Requester obligation: a requester must hold req_data, req_amt and req_dir stable while valid and not ready. The block does not check this.
- Reset mid-operation: a pending output is discarded. out_valid, rr_ptr and op_count clear asynchronously, and any in-flight result is lost.
- Unused packed slices cannot occur: NREQ sets the packed widths exactly.

Decomposition:
- Shared package rot_pkg:
  - Constant ROT_W=32 and localparam ROT_AMT_W=5.
  - Direction constants DIR_RIGHT=1'b0 and DIR_LEFT=1'b1.
  - Function left_to_right_amt(amt) returning (32-amt) mod 32.
- Sub-module rot32_core: purely combinational 32-bit right rotator with 5-bit amount, implemented as a 5-stage log shifter.
  - Instantiated once and fed by the arbiter mux.
  - The arbiter keeps the grant logic, output register and counter.

Test Plan:
- Single request on lane 0: data=0x80000001, amt=1, dir=right -> next cycle out_valid=1, out_data=0xC0000000, out_id=0; op_count=1 after the handshake with out_ready=1.
- Direction and boundary amounts on lane 2: 0x12345678 left 4 -> 0x23456781; 0x00000001 right 31 -> 0x00000002; 0xDEADBEEF amt=0 either direction -> 0xDEADBEEF.
- All four lanes valid continuously with out_ready=1 -> out_id sequence 0,1,2,3,0,1 on consecutive cycles, with no bubbles after the first result.
- Backpressure: out_ready=0 for 3 cycles with lanes 1 and 3 valid -> output holds its first result, req_ready=0, rr_ptr unchanged; after release the results arrive in order id 1 then 3.
- Pointer fairness: only lane 3 valid, then lanes 0 and 3 valid -> lane 3 granted first, then lane 0 (pointer wrapped to 0), then lane 3.
- Reset mid-operation: pulse rst_n low asynchronously while out_valid=1 and stalled -> out_valid, op_count and rr_ptr read 0 before the next clk edge, and the first post-reset grant goes to the lowest valid index.
